// File: rtl/bp_pkg.sv
// bp_pkg: 2-bit branch counter encodings, reset default and step function.
package bp_pkg;
  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT = 2'b10;
  localparam logic [1:0] BP_ST = 2'b11;
  localparam logic [1:0] CNT_INIT = BP_ST;
  function automatic logic [1:0] bp_next(input logic [1:0] cnt, input logic taken);
    return taken ? ((cnt == BP_ST) ? BP_ST : cnt + 2'd1)
                 : ((cnt == BP_SNT) ? BP_SNT : cnt - 2'd1);
  endfunction
endpackage

// File: rtl/sat_counter2.sv
// sat_counter2: one predictor table entry, a saturating 2-bit counter.
module sat_counter2
  import bp_pkg::*;
#(
  parameter logic [1:0] INIT = CNT_INIT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);
  logic [1:0] r_cnt;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) r_cnt <= INIT;
    else if (en_i) r_cnt <= bp_next(r_cnt, taken_i);
  assign cnt_o = r_cnt;
endmodule

// File: rtl/branch_predictor_unit.sv
// branch_predictor_unit: beq predictor with a counter table read in ID,
// resolved and updated in EX, plus saturating hit/miss statistics.
module branch_predictor_unit
  import bp_pkg::*;
#(
  parameter int         INDEX_BITS = 4,
  parameter logic [1:0] CNT_INIT   = bp_pkg::CNT_INIT,
  parameter int         STAT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              id_branch_i,
  input  logic [31:0]       id_pc_i,
  output logic              predict_taken_o,
  input  logic              ex_branch_i,
  input  logic [31:0]       ex_pc_i,
  input  logic              ex_predicted_i,
  input  logic              ex_zero_i,
  output logic              mispredict_o,
  output logic              redirect_taken_o,
  output logic [STAT_W-1:0] branch_cnt_o,
  output logic [STAT_W-1:0] miss_cnt_o
);
  localparam int N = 2 ** INDEX_BITS;
  logic [INDEX_BITS-1:0] w_idx_id, w_idx_ex;
  logic [1:0]            w_cnt [N];
  logic [N-1:0]          w_pred, w_lsb;
  logic                  w_upd, w_unused;
  logic [STAT_W-1:0]     r_branch_cnt, r_miss_cnt;
  assign w_idx_id = id_pc_i[INDEX_BITS+1:2];
  assign w_idx_ex = ex_pc_i[INDEX_BITS+1:2];
  assign w_upd    = ex_branch_i & ~stall_i;
  genvar g;
  for (g = 0; g < N; g++) begin : g_tbl
    sat_counter2 #(.INIT(CNT_INIT)) u_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (w_upd && (w_idx_ex == INDEX_BITS'(g))),
      .taken_i(ex_zero_i),
      .cnt_o  (w_cnt[g])
    );
    assign w_pred[g] = w_cnt[g][1];
    assign w_lsb[g]  = w_cnt[g][0];
  end
  // The ID read sees the pre-update entry; no bypass from the EX write.
  assign predict_taken_o  = id_branch_i & w_pred[w_idx_id];
  assign mispredict_o     = ex_branch_i & (ex_predicted_i != ex_zero_i);
  assign redirect_taken_o = ex_zero_i;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_branch_cnt <= '0;
      r_miss_cnt   <= '0;
    end else if (w_upd) begin
      if (~&r_branch_cnt) r_branch_cnt <= r_branch_cnt + STAT_W'(1);
      if (mispredict_o && ~&r_miss_cnt) r_miss_cnt <= r_miss_cnt + STAT_W'(1);
    end
  assign branch_cnt_o = r_branch_cnt;
  assign miss_cnt_o   = r_miss_cnt;
  assign w_unused = ^{id_pc_i[31:INDEX_BITS+2], id_pc_i[1:0],
                      ex_pc_i[31:INDEX_BITS+2], ex_pc_i[1:0], w_lsb};
endmodule

// File: tb/tb_branch_predictor_unit.sv
// tb_branch_predictor_unit: directed and random stimulus checked against a
// counter-table reference model; narrow stats so saturation is reached.
module tb_branch_predictor_unit;
  localparam int SW = 6;
  localparam int SMAX = (1 << SW) - 1;
  logic          clk_i = 0, rst_i = 0, stall_i = 0;
  logic          id_branch_i = 0, ex_branch_i = 0, ex_predicted_i = 0, ex_zero_i = 0;
  logic [31:0]   id_pc_i = 0, ex_pc_i = 0;
  logic          predict_taken_o, mispredict_o, redirect_taken_o;
  logic [SW-1:0] branch_cnt_o, miss_cnt_o;
  int tbl [16];
  int bc, mc, checks, errors;

  branch_predictor_unit #(.INDEX_BITS(4), .CNT_INIT(2'b11), .STAT_W(SW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
    .id_branch_i(id_branch_i), .id_pc_i(id_pc_i), .predict_taken_o(predict_taken_o),
    .ex_branch_i(ex_branch_i), .ex_pc_i(ex_pc_i), .ex_predicted_i(ex_predicted_i),
    .ex_zero_i(ex_zero_i), .mispredict_o(mispredict_o), .redirect_taken_o(redirect_taken_o),
    .branch_cnt_o(branch_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mpred(input logic [31:0] pc);
    return (tbl[pc[5:2]] >= 2) ? 1 : 0;
  endfunction

  task automatic model_reset();
    foreach (tbl[i]) tbl[i] = 3;
    bc = 0;
    mc = 0;
  endtask

  task automatic step(input logic idb, input logic [31:0] idpc, input logic exb,
                      input logic [31:0] expc, input logic expr, input logic z, input logic st);
    bit miss;
    id_branch_i = idb; id_pc_i = idpc; ex_branch_i = exb; ex_pc_i = expc;
    ex_predicted_i = expr; ex_zero_i = z; stall_i = st;
    #1;
    miss = exb && (expr != z);
    chk("predict", predict_taken_o, idb ? mpred(idpc) : 0);
    chk("mispredict", mispredict_o, miss);
    if (miss) chk("redirect", redirect_taken_o, z);
    @(posedge clk_i);
    if (exb && !st) begin
      tbl[expc[5:2]] = z ? (tbl[expc[5:2]] == 3 ? 3 : tbl[expc[5:2]] + 1)
                         : (tbl[expc[5:2]] == 0 ? 0 : tbl[expc[5:2]] - 1);
      if (bc < SMAX) bc++;
      if (miss && mc < SMAX) mc++;
    end
    #1;
    chk("branch_cnt", branch_cnt_o, bc);
    chk("miss_cnt", miss_cnt_o, mc);
  endtask

  task automatic async_reset();
    ex_branch_i = 1; ex_zero_i = 0; ex_predicted_i = 1; stall_i = 0;
    id_branch_i = 1; id_pc_i = $urandom;
    #1 rst_i = 0;
    model_reset();
    #1;
    chk("rst_branch_cnt", branch_cnt_o, 0);
    chk("rst_miss_cnt", miss_cnt_o, 0);
    chk("rst_predict", predict_taken_o, 1);
    rst_i = 1;
  endtask

  initial begin
    logic [31:0] pc_a, pc_b;
    logic        ex_b, pr;
    checks = 0; errors = 0;
    model_reset();
    #2;
    chk("reset_branch_cnt", branch_cnt_o, 0);
    chk("reset_miss_cnt", miss_cnt_o, 0);
    @(negedge clk_i) rst_i = 1;
    @(posedge clk_i); #1;
    step(1, 32'h10, 0, 0, 0, 0, 0);
    step(0, 32'h10, 0, 0, 0, 0, 0);
    step(1, 32'h10, 1, 32'h10, 1, 0, 0);
    step(1, 32'h10, 1, 32'h10, 1, 0, 0);
    step(1, 32'h10, 0, 0, 0, 0, 0);
    chk("predict_after_two_nt", predict_taken_o, 0);
    chk("dir_branch_cnt", branch_cnt_o, 2);
    chk("dir_miss_cnt", miss_cnt_o, 2);
    repeat (3) step(0, 0, 1, 32'h20, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 32'h20, 1, 32'h20, 0, 1, 0);
    chk("sat_entry8", tbl[8], 3);
    step(1, 32'h20, 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 1, 32'h30, 1, 0, 0);
    step(1, 32'h30, 1, 32'h30, 0, 1, 0);
    chk("same_cycle_old", predict_taken_o, 1);
    step(1, 32'h30, 0, 0, 0, 0, 0);
    repeat (3) step(1, 32'h30, 1, 32'h30, 1, 0, 1);
    step(1, 32'h30, 0, 0, 0, 0, 0);
    async_reset();
    repeat (2) step(0, 0, 1, 32'h04, 1, 0, 0);
    step(1, 32'h44, 0, 0, 0, 0, 0);
    chk("alias_0x44", predict_taken_o, 0);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      pc_a = {$urandom, 2'b00};
      pc_b = {$urandom, 2'b00};
      ex_b = $urandom_range(0, 3) != 0;
      pr = ($urandom_range(0, 3) == 0) ? 1'($urandom) : 1'(mpred(pc_b));
      step(1'($urandom), pc_a, ex_b, pc_b, pr, 1'($urandom), $urandom_range(0, 7) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
